duty_ramp: RTL and testbench

Slew-rate-limited duty setpoint generator directly upstream of the PWM stage. Accepts a target duty via a valid/ready handshake and moves its `duty` output toward that target in fixed steps at a fixed tick rate. This gives motors and LEDs a soft start and soft stop instead of step changes. Its `duty` output drives the PWM block's 8-bit `duty` input directly.

---
 rtl/duty_ramp_pkg.sv | 32 +++
 rtl/duty_ramp_step_tick.sv | 30 +++
 rtl/duty_ramp.sv | 117 +++++++++++
 tb/tb_duty_ramp.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duty_ramp_pkg.sv
// Shared types and constants for the duty_ramp slew-rate-limited setpoint generator.
package duty_ramp_pkg;

   localparam int unsigned DUTY_W       = 8;
   localparam int unsigned DEF_STEP_DIV = 50000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_UP     = 3'd1,
      ST_DOWN   = 3'd2,
      ST_DONE_P = 3'd3,
      ST_ESTOP  = 3'd4
   } state_t;

   // One step toward tgt; 9-bit intermediates so the last step clamps instead of wrapping.
   function automatic logic [DUTY_W-1:0] step_toward(
      input logic [DUTY_W-1:0] cur,
      input logic [DUTY_W-1:0] tgt,
      input logic [DUTY_W:0]   step,
      input logic              up
   );
      logic [DUTY_W:0] gap;
      gap = up ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});
      if (gap <= step)
         return tgt;
      else if (up)
         return DUTY_W'({1'b0, cur} + step);
      else
         return DUTY_W'({1'b0, cur} - step);
   endfunction

endpackage

// File: rtl/duty_ramp_step_tick.sv
// Ramp prescaler: counts 0..STEP_DIV-1 while enabled, pulses o_tick_c at terminal count.
module step_tick
   import duty_ramp_pkg::*;
#(
   parameter int unsigned STEP_DIV = DEF_STEP_DIV
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_tick_c
);

   localparam int unsigned     CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEP_DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   assign o_tick_c = i_enable && (r_cnt == LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_cnt <= '0;
      else if (i_clear)
         r_cnt <= '0;
      else if (i_enable)
         r_cnt <= o_tick_c ? '0 : r_cnt + CNT_W'(1);
   end

endmodule

// File: rtl/duty_ramp.sv
// Slew-rate-limited duty setpoint generator feeding the PWM stage.
// Optional emergency stop input and ESTOP state are built when DUTY_RAMP_ESTOP_EN is defined.
module duty_ramp
   import duty_ramp_pkg::*;
#(
   parameter int unsigned STEP_DIV = DEF_STEP_DIV,
   parameter int unsigned STEP     = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DUTY_W-1:0] target,
   input  logic              target_valid,
   output logic              target_ready,
`ifdef DUTY_RAMP_ESTOP_EN
   input  logic              estop,
`endif
   output logic [DUTY_W-1:0] duty,
   output logic              busy,
   output logic              done
);

   localparam logic [DUTY_W:0] STEP_W = (DUTY_W + 1)'(STEP);

   state_t            r_state, w_state_nxt;
   logic [DUTY_W-1:0] r_duty, w_duty_nxt;
   logic [DUTY_W-1:0] r_tgt, w_tgt_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_done, w_done_nxt;
   logic              r_ready, w_ready_nxt;
   logic              w_xfer, w_tick, w_clear, w_enable, w_estop, w_reach;
   logic [DUTY_W-1:0] w_step_val;

`ifdef DUTY_RAMP_ESTOP_EN
   assign w_estop = estop;
`else
   assign w_estop = 1'b0;
`endif

   assign w_xfer     = target_valid && r_ready;
   assign w_enable   = (r_state == ST_UP) || (r_state == ST_DOWN);
   assign w_step_val = step_toward(r_duty, r_tgt, STEP_W, r_state == ST_UP);
   assign w_reach    = (w_step_val == r_tgt);

   step_tick #(.STEP_DIV(STEP_DIV)) u_step_tick (
      .i_clk    (CLK),
      .i_rst    (RST),
      .i_clear  (w_clear),
      .i_enable (w_enable),
      .o_tick_c (w_tick)
   );

   // State and registered outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= ST_IDLE;
         r_duty  <= '0;
         r_tgt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_duty  <= w_duty_nxt;
         r_tgt   <= w_tgt_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_ready <= w_ready_nxt;
      end
   end

   // Next state: estop beats a transfer, a transfer beats a pending step
   always_comb begin
      w_state_nxt = r_state;
      if (w_estop) begin
         w_state_nxt = ST_ESTOP;
      end else if (w_xfer) begin
         if (target > r_duty)
            w_state_nxt = ST_UP;
         else if (target < r_duty)
            w_state_nxt = ST_DOWN;
         else
            w_state_nxt = ST_DONE_P;
      end else begin
         case (r_state)
            ST_UP, ST_DOWN: if (w_tick && w_reach) w_state_nxt = ST_DONE_P;
            ST_DONE_P:      w_state_nxt = ST_IDLE;
            ST_ESTOP:       w_state_nxt = ST_IDLE;
            default:        w_state_nxt = r_state;
         endcase
      end
   end

   // Next values of the datapath and output registers
   always_comb begin
      w_duty_nxt = r_duty;
      w_tgt_nxt  = r_tgt;
      w_clear    = 1'b0;
      if (w_estop) begin
         w_duty_nxt = '0;
         w_tgt_nxt  = '0;
      end else if (w_xfer) begin
         w_tgt_nxt = target;
         w_clear   = 1'b1;
      end else if (w_enable && w_tick) begin
         w_duty_nxt = w_step_val;
      end
      w_busy_nxt  = (w_state_nxt == ST_UP) || (w_state_nxt == ST_DOWN);
      w_done_nxt  = (r_state == ST_DONE_P) && !w_estop;
      w_ready_nxt = (w_state_nxt != ST_ESTOP);
   end

   assign duty         = r_duty;
   assign busy         = r_busy;
   assign done         = r_done;
   assign target_ready = r_ready;

endmodule

// File: tb/tb_duty_ramp.sv
// Self-checking bench for duty_ramp: directed scenarios plus a randomized retarget run
// compared against a closed-form ramp model (duty = d0 +/- min(floor(k/DIV)*STEP, |t-d0|)).
module tb_duty_ramp;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst_a, rst_b;
   logic [7:0] tgt_a, tgt_b;
   logic       val_a, val_b;
   logic       rdy_a, rdy_b;
   logic [7:0] duty_a, duty_b;
   logic       busy_a, busy_b, done_a, done_b;
`ifdef DUTY_RAMP_ESTOP_EN
   logic       estop_a, estop_b;
`endif

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   duty_ramp #(.STEP_DIV(DIV), .STEP(1)) u_dut_a (
      .CLK          (clk),
      .RST          (rst_a),
      .target       (tgt_a),
      .target_valid (val_a),
      .target_ready (rdy_a),
`ifdef DUTY_RAMP_ESTOP_EN
      .estop        (estop_a),
`endif
      .duty         (duty_a),
      .busy         (busy_a),
      .done         (done_a)
   );

   duty_ramp #(.STEP_DIV(DIV), .STEP(4)) u_dut_b (
      .CLK          (clk),
      .RST          (rst_b),
      .target       (tgt_b),
      .target_valid (val_b),
      .target_ready (rdy_b),
`ifdef DUTY_RAMP_ESTOP_EN
      .estop        (estop_b),
`endif
      .duty         (duty_b),
      .busy         (busy_b),
      .done         (done_b)
   );

   function automatic int n_steps(int d0, int t, int step);
      int diff;
      diff = (d0 > t) ? d0 - t : t - d0;
      return (diff + step - 1) / step;
   endfunction

   // Duty k cycles after a transfer edge that started from d0 toward t.
   function automatic int model_duty(int d0, int t, int k, int step);
      int moved;
      moved = (k / DIV) * step;
      if (t >= d0) return (d0 + moved > t) ? t : d0 + moved;
      else         return (d0 - moved < t) ? t : d0 - moved;
   endfunction

   function automatic logic model_busy(int d0, int t, int k, int step);
      return (d0 != t) && (k < n_steps(d0, t, step) * DIV);
   endfunction

   // True on the cycle the ramp has landed on target (done shows one edge later).
   function automatic logic model_land(int d0, int t, int k, int step);
      return k == n_steps(d0, t, step) * DIV;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_a();
      rst_a = 1'b1;
      cyc();
      rst_a = 1'b0;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1;
      cyc();
      vecs += 8;
      if (duty_a !== 8'd0) begin errs++; $display("FAIL reset duty_a got %0d want 0", duty_a); end
      if (busy_a !== 1'b0) begin errs++; $display("FAIL reset busy_a got %b want 0", busy_a); end
      if (done_a !== 1'b0) begin errs++; $display("FAIL reset done_a got %b want 0", done_a); end
      if (rdy_a  !== 1'b1) begin errs++; $display("FAIL reset ready_a got %b want 1", rdy_a); end
      if (duty_b !== 8'd0) begin errs++; $display("FAIL reset duty_b got %0d want 0", duty_b); end
      if (busy_b !== 1'b0) begin errs++; $display("FAIL reset busy_b got %b want 0", busy_b); end
      if (done_b !== 1'b0) begin errs++; $display("FAIL reset done_b got %b want 0", done_b); end
      if (rdy_b  !== 1'b1) begin errs++; $display("FAIL reset ready_b got %b want 1", rdy_b); end
      rst_a = 1'b0; rst_b = 1'b0;
      cyc();
   endtask

   task automatic test_ramp_up();
      int e;
      tgt_a = 8'd10; val_a = 1'b1;
      cyc();
      val_a = 1'b0;
      for (int k = 0; k <= 44; k++) begin
         if (k > 0) cyc();
         e = model_duty(0, 10, k, 1);
         vecs += 4;
         if (duty_a !== 8'(e)) begin errs++; $display("FAIL ramp_up duty k=%0d got %0d want %0d", k, duty_a, e); end
         if (busy_a !== model_busy(0, 10, k, 1)) begin errs++; $display("FAIL ramp_up busy k=%0d got %b", k, busy_a); end
         if (done_a !== (k == 41)) begin errs++; $display("FAIL ramp_up done k=%0d got %b want %b", k, done_a, k == 41); end
         if (rdy_a !== 1'b1) begin errs++; $display("FAIL ramp_up ready k=%0d got %b want 1", k, rdy_a); end
      end
   endtask

   task automatic test_clamp_down();
      int e, ndone, dmin;
      tgt_b = 8'd10; val_b = 1'b1;
      cyc();
      val_b = 1'b0;
      repeat (14) cyc();
      vecs++;
      if (duty_b !== 8'd10) begin errs++; $display("FAIL clamp_pre duty got %0d want 10", duty_b); end
      tgt_b = 8'd3; val_b = 1'b1;
      cyc();
      val_b = 1'b0;
      ndone = 0; dmin = 255;
      for (int k = 0; k <= 14; k++) begin
         if (k > 0) cyc();
         e = model_duty(10, 3, k, 4);
         if (done_b === 1'b1) ndone++;
         if (int'(duty_b) < dmin) dmin = int'(duty_b);
         vecs += 3;
         if (duty_b !== 8'(e)) begin errs++; $display("FAIL clamp duty k=%0d got %0d want %0d", k, duty_b, e); end
         if (busy_b !== model_busy(10, 3, k, 4)) begin errs++; $display("FAIL clamp busy k=%0d got %b", k, busy_b); end
         if (done_b !== (k == 9)) begin errs++; $display("FAIL clamp done k=%0d got %b want %b", k, done_b, k == 9); end
      end
      vecs += 2;
      if (ndone != 1) begin errs++; $display("FAIL clamp done_count got %0d want 1", ndone); end
      if (dmin < 3) begin errs++; $display("FAIL clamp undershoot min got %0d want >=3", dmin); end
   endtask

   task automatic test_retarget_tc();
      int e;
      reset_a();
      tgt_a = 8'd200; val_a = 1'b1;
      cyc();
      val_a = 1'b0;
      repeat (23) cyc();
      vecs++;
      if (duty_a !== 8'd5) begin errs++; $display("FAIL retarget_pre duty got %0d want 5", duty_a); end
      // This edge is also the prescaler terminal count
      tgt_a = 8'd2; val_a = 1'b1;
      cyc();
      val_a = 1'b0;
      for (int k = 0; k <= 15; k++) begin
         if (k > 0) cyc();
         e = model_duty(5, 2, k, 1);
         vecs += 3;
         if (duty_a !== 8'(e)) begin errs++; $display("FAIL retarget duty k=%0d got %0d want %0d", k, duty_a, e); end
         if (busy_a !== model_busy(5, 2, k, 1)) begin errs++; $display("FAIL retarget busy k=%0d got %b", k, busy_a); end
         if (done_a !== (k == 13)) begin errs++; $display("FAIL retarget done k=%0d got %b want %b", k, done_a, k == 13); end
      end
   endtask

   task automatic test_equal();
      int ndone;
      reset_a();
      tgt_a = 8'd0; val_a = 1'b1;
      cyc();
      val_a = 1'b0;
      ndone = 0;
      for (int k = 0; k <= 5; k++) begin
         if (k > 0) cyc();
         if (done_a === 1'b1) ndone++;
         vecs += 3;
         if (duty_a !== 8'd0) begin errs++; $display("FAIL equal duty k=%0d got %0d want 0", k, duty_a); end
         if (busy_a !== 1'b0) begin errs++; $display("FAIL equal busy k=%0d got %b want 0", k, busy_a); end
         if (done_a !== (k == 1)) begin errs++; $display("FAIL equal done k=%0d got %b want %b", k, done_a, k == 1); end
      end
      vecs++;
      if (ndone != 1) begin errs++; $display("FAIL equal done_count got %0d want 1", ndone); end
   endtask

`ifdef DUTY_RAMP_ESTOP_EN
   task automatic test_estop();
      reset_a();
      tgt_a = 8'd200; val_a = 1'b1;
      cyc();
      val_a = 1'b0;
      repeat (480) cyc();
      vecs++;
      if (duty_a !== 8'd120) begin errs++; $display("FAIL estop_pre duty got %0d want 120", duty_a); end
      estop_a = 1'b1; tgt_a = 8'd50; val_a = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         vecs += 4;
         if (duty_a !== 8'd0) begin errs++; $display("FAIL estop duty k=%0d got %0d want 0", k, duty_a); end
         if (rdy_a !== 1'b0) begin errs++; $display("FAIL estop ready k=%0d got %b want 0", k, rdy_a); end
         if (busy_a !== 1'b0) begin errs++; $display("FAIL estop busy k=%0d got %b want 0", k, busy_a); end
         if (done_a !== 1'b0) begin errs++; $display("FAIL estop done k=%0d got %b want 0", k, done_a); end
      end
      val_a = 1'b0; estop_a = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         vecs += 4;
         if (rdy_a !== 1'b1) begin errs++; $display("FAIL estop_exit ready k=%0d got %b want 1", k, rdy_a); end
         if (duty_a !== 8'd0) begin errs++; $display("FAIL estop_exit duty k=%0d got %0d want 0", k, duty_a); end
         if (busy_a !== 1'b0) begin errs++; $display("FAIL estop_exit busy k=%0d got %b want 0", k, busy_a); end
         if (done_a !== 1'b0) begin errs++; $display("FAIL estop_exit done k=%0d got %b want 0", k, done_a); end
      end
   endtask
`endif

   task automatic test_async_reset();
      reset_a();
      tgt_a = 8'd50; val_a = 1'b1;
      cyc();
      val_a = 1'b0;
      repeat (100) cyc();
      vecs++;
      if (duty_a !== 8'd25) begin errs++; $display("FAIL async_pre duty got %0d want 25", duty_a); end
      #2;
      rst_a = 1'b1;
      #1;
      vecs += 3;
      if (duty_a !== 8'd0) begin errs++; $display("FAIL async duty got %0d want 0", duty_a); end
      if (busy_a !== 1'b0) begin errs++; $display("FAIL async busy got %b want 0", busy_a); end
      if (rdy_a !== 1'b1) begin errs++; $display("FAIL async ready got %b want 1", rdy_a); end
      cyc();
      rst_a = 1'b0;
      cyc();
   endtask

   task automatic test_random();
      int seg_d0, seg_t, seg_k, cur, t;
      logic xfer, land_prev, exp_done, exp_busy;
      reset_a();
      seg_d0 = 0; seg_t = 0; seg_k = 1000; cur = 0; land_prev = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         xfer = ($urandom_range(0, 59) == 0);
         t = int'($urandom_range(0, 255));
         if (xfer && $urandom_range(0, 7) == 0) t = cur;
         tgt_a = 8'(t);
         val_a = xfer;
         cyc();
         val_a = 1'b0;
         exp_done = land_prev;
         if (xfer) begin
            seg_d0 = cur; seg_t = t; seg_k = 0;
         end else begin
            seg_k++;
         end
         cur       = model_duty(seg_d0, seg_t, seg_k, 1);
         exp_busy  = model_busy(seg_d0, seg_t, seg_k, 1);
         land_prev = model_land(seg_d0, seg_t, seg_k, 1);
         vecs += 4;
         if (duty_a !== 8'(cur)) begin errs++; $display("FAIL random duty n=%0d got %0d want %0d", n, duty_a, cur); end
         if (busy_a !== exp_busy) begin errs++; $display("FAIL random busy n=%0d got %b want %b", n, busy_a, exp_busy); end
         if (done_a !== exp_done) begin errs++; $display("FAIL random done n=%0d got %b want %b", n, done_a, exp_done); end
         if (rdy_a !== 1'b1) begin errs++; $display("FAIL random ready n=%0d got %b want 1", n, rdy_a); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      tgt_a = '0; tgt_b = '0;
      val_a = 1'b0; val_b = 1'b0;
`ifdef DUTY_RAMP_ESTOP_EN
      estop_a = 1'b0; estop_b = 1'b0;
`endif
      #1;
      test_reset();
      test_ramp_up();
      test_clamp_down();
      test_retarget_tc();
      test_equal();
`ifdef DUTY_RAMP_ESTOP_EN
      test_estop();
`endif
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
